spgd_update: RTL and testbench

- Downstream consumer of the ADC metric averager in the SPGD loop.
- Each iteration applies a random ± perturbation to N_CH DAC channels, then has the averager measure the metric J+ and J-, one per polarity.
- Forms dJ = J+ − J- and updates every channel by a signed, shifted gradient step, saturating at the DAC rails.
- Drives the averager's enable, consumes its done/data pair, and feeds the DAC interface.

---
 rtl/spgd_pkg.sv | 30 +++
 rtl/spgd_lfsr16.sv | 35 +++
 rtl/spgd_update.sv | 180 ++++++++++++++++++
 tb/tb_spgd_update.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spgd_pkg.sv
// Shared definitions for the SPGD update block.
// - FSM state encodings (4-bit localparams).
// - LFSR tap mask for x^16 + x^14 + x^13 + x^11 + 1.
// - DAC mid-code and upper rail as functions of the DAC width.
package spgd_pkg;

  localparam logic [3:0] StIdle    = 4'd0;
  localparam logic [3:0] StApplyP  = 4'd1;
  localparam logic [3:0] StSettleP = 4'd2;
  localparam logic [3:0] StMeasP   = 4'd3;
  localparam logic [3:0] StCapP    = 4'd4;
  localparam logic [3:0] StClr     = 4'd5;
  localparam logic [3:0] StApplyM  = 4'd6;
  localparam logic [3:0] StSettleM = 4'd7;
  localparam logic [3:0] StMeasM   = 4'd8;
  localparam logic [3:0] StCapM    = 4'd9;
  localparam logic [3:0] StUpdate  = 4'd10;

  // Right-shifting Fibonacci form: feedback is the XOR of bits 0, 2, 3 and 5.
  localparam logic [15:0] LfsrTaps = 16'h002D;

  function automatic int unsigned dac_mid(input int unsigned width);
    return 32'd1 << (width - 1);
  endfunction

  function automatic int unsigned dac_max(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/spgd_lfsr16.sv
// 16-bit Fibonacci LFSR used as the per-iteration sign source.
// Ports:
//   clk_i   - clock
//   rst_i   - asynchronous active-high reset, loads Seed
//   step_i  - advance one position this cycle
//   state_o - current register contents
module spgd_lfsr16 import spgd_pkg::*; #(
  parameter logic [15:0] Seed = 16'hACE1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        step_i,
  output logic [15:0] state_o
);

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (step_i) begin
      lfsr_d = {^(lfsr_q & LfsrTaps), lfsr_q[15:1]};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lfsr_q <= Seed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/spgd_update.sv
// SPGD gradient-step engine. Each iteration perturbs every DAC channel by
// +/-PERT_AMP, has the metric averager measure J+ and J-, then moves every
// channel by sign * ((J+ - J-) >>> GAIN_SHIFT), clamped to the DAC rails.
// Ports:
//   clk_i, rst_i     - clock, asynchronous active-high reset
//   start_i          - run enable (level); an iteration in flight always completes
//   metric_done_i    - averager done flag, only honoured in the measure states
//   metric_in_i      - signed averaged metric, valid the cycle after done rises
//   avg_en_o         - averager enable; low clears the averager
//   dac_out_o        - packed channel codes, channel k at [k*DAC_WIDTH +: DAC_WIDTH]
//   dac_valid_o      - one-cycle strobe whenever dac_out_o changes
//   busy_o           - high outside idle
//   iter_count_o     - completed iterations, wrapping
module spgd_update import spgd_pkg::*; #(
  parameter int unsigned ADC_WIDTH     = 12,
  parameter int unsigned DAC_WIDTH     = 14,
  parameter int unsigned N_CH          = 4,   // 1..16, one LFSR bit per channel
  parameter int unsigned PERT_AMP      = 64,
  parameter int unsigned GAIN_SHIFT    = 2,
  parameter int unsigned SETTLE_CYCLES = 100,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  input  logic                      metric_done_i,
  input  logic [ADC_WIDTH-1:0]      metric_in_i,
  output logic                      avg_en_o,
  output logic [N_CH*DAC_WIDTH-1:0] dac_out_o,
  output logic                      dac_valid_o,
  output logic                      busy_o,
  output logic [31:0]               iter_count_o
);

  // Two guard bits above the wider operand so sums never wrap before clamping.
  localparam int unsigned SumW = ((DAC_WIDTH > ADC_WIDTH + 1) ? DAC_WIDTH : ADC_WIDTH + 1) + 2;
  localparam int unsigned CntW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic signed [SumW-1:0] SumMax     = SumW'(dac_max(DAC_WIDTH));
  localparam logic signed [SumW-1:0] Pert       = SumW'(PERT_AMP);
  localparam logic [DAC_WIDTH-1:0]   UMid       = DAC_WIDTH'(dac_mid(DAC_WIDTH));
  localparam logic [CntW-1:0]        SettleLoad = CntW'(SETTLE_CYCLES - 1);

  logic [3:0]                  state_q, state_d;
  logic [CntW-1:0]             cnt_q, cnt_d;
  logic signed [ADC_WIDTH-1:0] jp_q, jp_d, jm_q, jm_d;
  logic [31:0]                 iter_q, iter_d;
  logic [DAC_WIDTH-1:0]        u_q [N_CH];
  logic [DAC_WIDTH-1:0]        u_d [N_CH];
  logic [DAC_WIDTH-1:0]        u_new [N_CH];
  logic [15:0]                 lfsr;
  logic                        unused_lfsr;
  logic                        upd, plus_ph, minus_ph;
  logic signed [ADC_WIDTH:0]   dj;
  logic signed [SumW-1:0]      step;

  function automatic logic [DAC_WIDTH-1:0] sat_dac(input logic signed [SumW-1:0] v);
    if (v < 0) return '0;
    if (v > SumMax) return SumMax[DAC_WIDTH-1:0];
    return v[DAC_WIDTH-1:0];
  endfunction

  spgd_lfsr16 #(
    .Seed(LFSR_SEED)
  ) u_lfsr (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .step_i (upd),
    .state_o(lfsr)
  );

  // Bits beyond N_CH only feed the LFSR recurrence.
  assign unused_lfsr = ^lfsr;

  assign upd      = (state_q == StUpdate);
  assign plus_ph  = (state_q == StApplyP) || (state_q == StSettleP) || (state_q == StMeasP) ||
                    (state_q == StCapP) || (state_q == StClr);
  assign minus_ph = (state_q == StApplyM) || (state_q == StSettleM) || (state_q == StMeasM) ||
                    (state_q == StCapM);

  // Decoded straight from state so a reset drops the enable without a clock.
  assign avg_en_o     = (state_q == StMeasP) || (state_q == StCapP) ||
                        (state_q == StMeasM) || (state_q == StCapM);
  assign dac_valid_o  = (state_q == StApplyP) || (state_q == StApplyM) || upd;
  assign busy_o       = (state_q != StIdle);
  assign iter_count_o = iter_q;

  assign dj   = $signed({jp_q[ADC_WIDTH-1], jp_q}) - $signed({jm_q[ADC_WIDTH-1], jm_q});
  assign step = SumW'(dj) >>> GAIN_SHIFT;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    logic signed [SumW-1:0] u_ext, pert_k, step_k;
    logic [DAC_WIDTH-1:0]   ch_out;

    assign u_ext    = $signed({{(SumW - DAC_WIDTH){1'b0}}, u_q[k]});
    assign pert_k   = lfsr[k] ? -Pert : Pert;
    assign step_k   = lfsr[k] ? -step : step;
    assign u_new[k] = sat_dac(u_ext + step_k);

    always_comb begin
      ch_out = u_q[k];
      if (upd) begin
        ch_out = u_new[k];
      end else if (plus_ph) begin
        ch_out = sat_dac(u_ext + pert_k);
      end else if (minus_ph) begin
        ch_out = sat_dac(u_ext - pert_k);
      end
    end

    assign dac_out_o[k*DAC_WIDTH +: DAC_WIDTH] = ch_out;
  end

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      u_d[i] = upd ? u_new[i] : u_q[i];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    jp_d    = jp_q;
    jm_d    = jm_q;
    iter_d  = iter_q;
    case (state_q)
      StIdle:    if (start_i) state_d = StApplyP;
      StApplyP: begin
        cnt_d   = SettleLoad;
        state_d = StSettleP;
      end
      StSettleP: begin
        if (cnt_q == '0) state_d = StMeasP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      StMeasP:   if (metric_done_i) state_d = StCapP;
      StCapP: begin
        jp_d    = metric_in_i;
        state_d = StClr;
      end
      StClr:     state_d = StApplyM;
      StApplyM: begin
        cnt_d   = SettleLoad;
        state_d = StSettleM;
      end
      StSettleM: begin
        if (cnt_q == '0) state_d = StMeasM;
        else             cnt_d   = cnt_q - 1'b1;
      end
      StMeasM:   if (metric_done_i) state_d = StCapM;
      StCapM: begin
        jm_d    = metric_in_i;
        state_d = StUpdate;
      end
      StUpdate: begin
        iter_d  = iter_q + 32'd1;
        state_d = start_i ? StApplyP : StIdle;
      end
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      jp_q    <= '0;
      jm_q    <= '0;
      iter_q  <= '0;
      for (int i = 0; i < N_CH; i++) u_q[i] <= UMid;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      jp_q    <= jp_d;
      jm_q    <= jm_d;
      iter_q  <= iter_d;
      for (int i = 0; i < N_CH; i++) u_q[i] <= u_d[i];
    end
  end

endmodule

// File: tb/tb_spgd_update.sv
// Self-checking bench for spgd_update with a behavioural metric averager.
module tb_spgd_update;

  localparam int DW     = 14;
  localparam int NCH    = 4;
  localparam int SETTLE = 5;
  localparam int PERT   = 64;
  localparam int DMAX   = 16383;
  localparam int GARB   = 12'h5A5;

  logic              clk = 1'b0;
  logic              rst, start, glitch_done, mdl_done, metric_done;
  logic [11:0]       metric_in;
  logic              avg_en, dac_valid, busy;
  logic [NCH*DW-1:0] dac_out;
  logic [31:0]       iter_count;

  assign metric_done = mdl_done | glitch_done;

  always #5 clk = ~clk;

  spgd_update #(
    .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .metric_done_i(metric_done),
    .metric_in_i  (metric_in),
    .avg_en_o     (avg_en),
    .dac_out_o    (dac_out),
    .dac_valid_o  (dac_valid),
    .busy_o       (busy),
    .iter_count_o (iter_count)
  );

  int          checks = 0;
  int          errors = 0;
  int          t_avg, jp_v, jm_v, acnt, vcount;
  bit          phase_m, prev_en_m;
  int          exp_u [NCH];
  logic [15:0] lfsr_m;
  int          exp_iter;

  typedef struct {
    int jp;
    int jm;
    int step;
  } vec_t;
  vec_t vecs [6];

  // Averager model: done rises after t_avg enabled cycles and stays up;
  // the metric is garbage until the cycle after done rises.
  initial begin
    mdl_done = 1'b0; metric_in = 12'(GARB); acnt = 0; phase_m = 1'b0; prev_en_m = 1'b0;
    vcount = 0;
  end
  always @(negedge clk) begin
    if (dac_valid) vcount++;
    if (rst || !avg_en) begin
      acnt = 0;
      mdl_done = 1'b0;
      metric_in = 12'(GARB);
    end else begin
      metric_in = mdl_done ? 12'(phase_m ? jm_v : jp_v) : 12'(GARB);
      if (acnt >= t_avg) mdl_done = 1'b1;
      acnt++;
    end
    if (rst) phase_m = 1'b0;
    else if (prev_en_m && !avg_en) phase_m = ~phase_m;
    prev_en_m = avg_en;
  end

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  function automatic int sat(input int v);
    if (v < 0) return 0;
    if (v > DMAX) return DMAX;
    return v;
  endfunction

  function automatic int ch(input int k);
    return int'(dac_out[k*DW +: DW]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_model();
    for (int k = 0; k < NCH; k++) exp_u[k] = 8192;
    lfsr_m   = 16'hACE1;
    exp_iter = 0;
  endtask

  task automatic check_all_mid(input string name);
    for (int k = 0; k < NCH; k++) check($sformatf("%s[%0d]", name, k), ch(k), 8192);
  endtask

  // One full iteration; returns sampled in UPDATE (keep=1) or in IDLE (keep=0).
  task automatic run_iter(input int jp, input int jm, input int step, input bit keep,
                          input bit rel, input bit glt);
    int pulses = 0;
    int cyc = 0;
    int hi = 0;
    int fall_cyc = -10;
    int rel_at = -1;
    int glt_at = -1;
    bit prev_en = 1'b0;
    int sg;
    jp_v  = jp;
    jm_v  = jm;
    start = 1'b1;
    while (pulses < 3 && cyc < 2000) begin
      tick();
      cyc++;
      if (cyc == rel_at) start = 1'b0;
      if (glt_at > 0 && cyc == glt_at) glitch_done = 1'b1;
      if (glt_at > 0 && cyc == glt_at + 1) begin
        glitch_done = 1'b0;
        check("done_ignored_in_settle", avg_en, 0);
      end
      if (avg_en) hi++;
      if (prev_en && !avg_en) begin
        check("avg_en_high_cycles", hi, t_avg + 2);
        hi = 0;
        fall_cyc = cyc;
      end
      if (dac_valid) begin
        pulses++;
        if (pulses == 1) begin
          check("busy_in_iter", busy, 1);
          for (int k = 0; k < NCH; k++) begin
            sg = lfsr_m[k] ? -1 : 1;
            check($sformatf("dac_plus[%0d]", k), ch(k), sat(exp_u[k] + sg * PERT));
          end
          if (glt) glt_at = cyc + 1;
        end else if (pulses == 2) begin
          check("clr_one_cycle", cyc - fall_cyc, 1);
          for (int k = 0; k < NCH; k++) begin
            sg = lfsr_m[k] ? -1 : 1;
            check($sformatf("dac_minus[%0d]", k), ch(k), sat(exp_u[k] - sg * PERT));
          end
          if (rel) rel_at = cyc + 1;
        end else begin
          check("update_after_cap", cyc - fall_cyc, 0);
          check("avg_en_low_update", avg_en, 0);
          for (int k = 0; k < NCH; k++) begin
            sg = lfsr_m[k] ? -1 : 1;
            exp_u[k] = sat(exp_u[k] + sg * step);
            check($sformatf("dac_update[%0d]", k), ch(k), exp_u[k]);
          end
        end
      end
      prev_en = avg_en;
    end
    if (pulses < 3) begin
      check("iter_timeout_pulses", pulses, 3);
      start = 1'b0;
    end else begin
      lfsr_m = {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
      exp_iter++;
      if (!keep) begin
        start = 1'b0;
        tick();
        check("idle_busy", busy, 0);
        check("iter_count", int'(iter_count), exp_iter);
      end
    end
  endtask

  initial begin
    int w;
    rst = 1'b1; start = 1'b0; glitch_done = 1'b0; t_avg = 10; jp_v = 0; jm_v = 0;
    reset_model();
    vecs[0] = '{400, 200, 50};
    vecs[1] = '{-100, -20, -20};
    vecs[2] = '{7, 0, 1};
    vecs[3] = '{0, 7, -2};
    vecs[4] = '{-2048, 2047, -1024};
    vecs[5] = '{2047, -2048, 1023};

    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_avg_en", avg_en, 0);
    check("rst_dac_valid", dac_valid, 0);
    check("rst_iter", int'(iter_count), 0);
    check_all_mid("rst_dac");
    @(negedge clk) rst = 1'b0;
    tick();
    check("idle_after_reset", busy, 0);

    // Done pulse while idle must not start anything.
    glitch_done = 1'b1;
    tick();
    glitch_done = 1'b0;
    tick();
    check("done_ignored_idle_busy", busy, 0);
    check("done_ignored_idle_valid", dac_valid, 0);

    for (int i = 0; i < 6; i++) begin
      vcount = 0;
      run_iter(vecs[i].jp, vecs[i].jm, vecs[i].step, 1'b0, 1'b0, i == 0);
      check($sformatf("valid_pulses_vec%0d", i), vcount, 3);
      if (i == 0) begin
        check("single_ch0", ch(0), 8142);
        for (int k = 1; k < NCH; k++) check($sformatf("single_ch%0d", k), ch(k), 8242);
        check("single_iter", int'(iter_count), 1);
      end
      if (i == 1) begin
        check("neg_ch0", ch(0), 8122);
        for (int k = 1; k < NCH; k++) check($sformatf("neg_ch%0d", k), ch(k), 8222);
      end
    end

    // Done already high on the first measure cycle.
    t_avg = 0;
    run_iter(400, 200, 50, 1'b0, 1'b0, 1'b0);

    // Release start during SETTLE_M: iteration completes, then stays idle.
    t_avg = 3;
    vcount = 0;
    run_iter(-300, 100, -100, 1'b0, 1'b1, 1'b0);
    repeat (5) tick();
    check("release_stays_idle", busy, 0);
    check("release_valid_pulses", vcount, 3);
    run_iter(100, -100, 50, 1'b0, 1'b0, 1'b0);

    // Drive channel 0 into the upper rail, then the lower rail.
    t_avg = 1;
    for (int n = 0; n < 24; n++) begin
      if (lfsr_m[0] == 1'b0) run_iter(2047, 0, 511, n < 23, 1'b0, 1'b0);
      else                   run_iter(0, 2047, -512, n < 23, 1'b0, 1'b0);
    end
    check("sat_high_ch0", ch(0), 16383);
    for (int n = 0; n < 40; n++) begin
      if (lfsr_m[0] == 1'b0) run_iter(0, 2047, -512, n < 39, 1'b0, 1'b0);
      else                   run_iter(2047, 0, 511, n < 39, 1'b0, 1'b0);
    end
    check("sat_low_ch0", ch(0), 0);

    // Asynchronous reset in the middle of MEAS_P.
    t_avg = 10;
    jp_v = 400;
    start = 1'b1;
    w = 0;
    while (!avg_en && w < 200) begin
      tick();
      w++;
    end
    check("reach_meas_p", avg_en, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_avg_en", avg_en, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", dac_valid, 0);
    check("mid_rst_iter", int'(iter_count), 0);
    check_all_mid("mid_rst_dac");
    start = 1'b0;
    reset_model();
    tick();
    @(negedge clk) rst = 1'b0;
    tick();

    run_iter(400, 200, 50, 1'b0, 1'b0, 1'b0);
    check("post_rst_ch0", ch(0), 8142);
    check("post_rst_ch1", ch(1), 8242);
    check("post_rst_iter", int'(iter_count), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
